// File: rtl/m_bldcm_dead_time.sv
// Gate-drive conditioning for a three-leg BLDC bridge.
// Each leg gets a dead-band FSM, a shoot-through fault latch and per-pin output polarity.
module m_bldcm_dead_time #(
  parameter int pDeadCycles = 16,
  parameter int pCntWidth   = 8,
  parameter bit pInvertUh   = 1'b0,
  parameter bit pInvertUl   = 1'b0,
  parameter bit pInvertVh   = 1'b0,
  parameter bit pInvertVl   = 1'b0,
  parameter bit pInvertWh   = 1'b0,
  parameter bit pInvertWl   = 1'b0
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic       iFaultClear,
  input  logic       iUh,
  input  logic       iUl,
  input  logic       iVh,
  input  logic       iVl,
  input  logic       iWh,
  input  logic       iWl,
  output logic       oUh,
  output logic       oUl,
  output logic       oVh,
  output logic       oVl,
  output logic       oWh,
  output logic       oWl,
  output logic [2:0] oFault,
  output logic [5:0] oLegState
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON_H = 2'd1,
    ON_L = 2'd2
  } legState_t;

  localparam logic [pCntWidth-1:0] cCntMax = pCntWidth'(pDeadCycles - 1);

  logic [2:0] reqH;
  logic [2:0] reqL;
  logic [2:0] shoot;
  logic [2:0] drvH;
  logic [2:0] drvL;
  logic       allow;

  assign reqH  = {iWh, iVh, iUh};
  assign reqL  = {iWl, iVl, iUl};
  assign shoot = reqH & reqL;
  assign allow = iEnable & ~|oFault;

  // Set dominates clear so a shoot-through in the clear cycle is never lost.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oFault <= 3'b000;
    end else begin
      oFault <= shoot | (oFault & {3{~iFaultClear}});
    end
  end

  for (genvar gLeg = 0; gLeg < 3; gLeg++) begin : gLegFsm
    legState_t            state;
    legState_t            stateNext;
    logic [pCntWidth-1:0] cnt;
    logic [pCntWidth-1:0] cntNext;
    logic                 legDrvH;
    logic                 legDrvL;

    always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
        state <= OFF;
        cnt   <= '0;
      end else begin
        state <= stateNext;
        cnt   <= cntNext;
      end
    end

    // cnt counts both-off cycles since the last drop; turn-on needs it saturated.
    always_comb begin
      stateNext = state;
      cntNext   = cnt;
      unique case (state)
        OFF: begin
          if (cnt != cCntMax) begin
            cntNext = cnt + pCntWidth'(1);
          end
          if (allow && reqH[gLeg] && !reqL[gLeg] && (cnt == cCntMax)) begin
            stateNext = ON_H;
          end else if (allow && reqL[gLeg] && !reqH[gLeg] && (cnt == cCntMax)) begin
            stateNext = ON_L;
          end
        end
        ON_H: begin
          if (!reqH[gLeg] || reqL[gLeg] || !allow) begin
            stateNext = OFF;
            cntNext   = '0;
          end
        end
        ON_L: begin
          if (!reqL[gLeg] || reqH[gLeg] || !allow) begin
            stateNext = OFF;
            cntNext   = '0;
          end
        end
        default: begin
          stateNext = OFF;
          cntNext   = '0;
        end
      endcase
    end

    always_comb begin
      legDrvH = (state == ON_H);
      legDrvL = (state == ON_L);
    end

    assign drvH[gLeg]              = legDrvH;
    assign drvL[gLeg]              = legDrvL;
    assign oLegState[2*gLeg +: 2]  = state;
  end

  assign oUh = drvH[0] ^ pInvertUh;
  assign oUl = drvL[0] ^ pInvertUl;
  assign oVh = drvH[1] ^ pInvertVh;
  assign oVl = drvL[1] ^ pInvertVl;
  assign oWh = drvH[2] ^ pInvertWh;
  assign oWl = drvL[2] ^ pInvertWl;

endmodule

// File: tb/tb_m_bldcm_dead_time.sv
// Bench for m_bldcm_dead_time: two instances (dead band 4 and 1, different pin polarities)
// share stimulus and are checked against a timestamp-based model of the dead-band rules.
module tb_m_bldcm_dead_time;

  localparam logic [5:0] cMaskA = 6'b001001; // {Uh,Ul,Vh,Vl,Wh,Wl} pin inversions, instance A
  localparam logic [5:0] cMaskB = 6'b010000;
  localparam int cDeadA = 4;
  localparam int cDeadB = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic uh = 1'b0, ul = 1'b0, vh = 1'b0, vl = 1'b0, wh = 1'b0, wl = 1'b0;

  logic aUh, aUl, aVh, aVl, aWh, aWl;
  logic bUh, bUl, bVh, bVl, bWh, bWl;
  logic [2:0] aFault, bFault;
  logic [5:0] aDbg, bDbg;
  logic [5:0] pinsA, pinsB;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  m_bldcm_dead_time #(.pDeadCycles(cDeadA), .pCntWidth(8), .pInvertVh(1'b1), .pInvertWl(1'b1)) dutA (
    .iClock(clk), .iReset(rst), .iEnable(en), .iFaultClear(clr),
    .iUh(uh), .iUl(ul), .iVh(vh), .iVl(vl), .iWh(wh), .iWl(wl),
    .oUh(aUh), .oUl(aUl), .oVh(aVh), .oVl(aVl), .oWh(aWh), .oWl(aWl),
    .oFault(aFault), .oLegState(aDbg)
  );

  m_bldcm_dead_time #(.pDeadCycles(cDeadB), .pCntWidth(4), .pInvertUl(1'b1)) dutB (
    .iClock(clk), .iReset(rst), .iEnable(en), .iFaultClear(clr),
    .iUh(uh), .iUl(ul), .iVh(vh), .iVl(vl), .iWh(wh), .iWl(wl),
    .oUh(bUh), .oUl(bUl), .oVh(bVh), .oVl(bVl), .oWh(bWh), .oWl(bWl),
    .oFault(bFault), .oLegState(bDbg)
  );

  assign pinsA = {aUh, aUl, aVh, aVl, aWh, aWl};
  assign pinsB = {bUh, bUl, bVh, bVl, bWh, bWl};

  // ---------------- reference model ----------------
  // Per leg: 0 = off, 1 = high on, 2 = low on. A switch may turn on at edge n only
  // if n - (edge at which the leg last dropped or was reset) >= dead band.
  int         mState [2][3];
  longint     mDrop  [2][3];
  logic [2:0] mFault [2];
  longint     edgeN = 0;

  task automatic model_reset(input longint n);
    for (int i = 0; i < 2; i++) begin
      mFault[i] = 3'b000;
      for (int l = 0; l < 3; l++) begin
        mState[i][l] = 0;
        mDrop[i][l]  = n;
      end
    end
  endtask

  always @(posedge rst) model_reset(edgeN);

  always @(posedge clk) begin
    longint n;
    logic [2:0] rh, rl, nf;
    bit allow;
    int dead;
    n = edgeN;
    edgeN++;
    if (rst) begin
      model_reset(n);
    end else begin
      rh = {wh, vh, uh};
      rl = {wl, vl, ul};
      for (int i = 0; i < 2; i++) begin
        dead  = (i == 0) ? cDeadA : cDeadB;
        allow = en && (mFault[i] == 3'b000);
        nf    = (rh & rl) | (mFault[i] & {3{~clr}});
        for (int l = 0; l < 3; l++) begin
          if (mState[i][l] == 1) begin
            if (!rh[l] || rl[l] || !allow) begin mState[i][l] = 0; mDrop[i][l] = n; end
          end else if (mState[i][l] == 2) begin
            if (!rl[l] || rh[l] || !allow) begin mState[i][l] = 0; mDrop[i][l] = n; end
          end else if (allow && (n - mDrop[i][l] >= longint'(dead))) begin
            if (rh[l] && !rl[l]) mState[i][l] = 1;
            else if (rl[l] && !rh[l]) mState[i][l] = 2;
          end
        end
        mFault[i] = nf;
      end
    end
  end

  function automatic logic [5:0] exp_drv(input int i);
    logic [5:0] d;
    d = '0;
    for (int l = 0; l < 3; l++) begin
      d[5-2*l] = (mState[i][l] == 1);
      d[4-2*l] = (mState[i][l] == 2);
    end
    return d;
  endfunction

  // Scoreboard: every falling edge, both instances against the model.
  always @(negedge clk) begin
    logic [8:0] expA, expB;
    expA = {mFault[0], exp_drv(0) ^ cMaskA};
    expB = {mFault[1], exp_drv(1) ^ cMaskB};
    nAssert++;
    if ({aFault, pinsA} !== expA) begin
      nFail++;
      $display("FAIL model_a t=%0t got=%b exp=%b", $time, {aFault, pinsA}, expA);
    end
    nAssert++;
    if ({bFault, pinsB} !== expB) begin
      nFail++;
      $display("FAIL model_b t=%0t got=%b exp=%b", $time, {bFault, pinsB}, expB);
    end
  end

  // Continuous non-overlap check: no leg drives both sides, and no side rises
  // in the sample right after the opposite side was on.
  logic [5:0] prevDrvA = '0, prevDrvB = '0;
  always @(negedge clk) begin
    logic [5:0] dA, dB;
    bit badA, badB;
    if (rst) begin
      prevDrvA = '0;
      prevDrvB = '0;
    end else begin
      dA = pinsA ^ cMaskA;
      dB = pinsB ^ cMaskB;
      badA = 1'b0;
      badB = 1'b0;
      for (int l = 0; l < 3; l++) begin
        if (dA[5-2*l] && (dA[4-2*l] || prevDrvA[4-2*l])) badA = 1'b1;
        if (dA[4-2*l] && prevDrvA[5-2*l]) badA = 1'b1;
        if (dB[5-2*l] && (dB[4-2*l] || prevDrvB[4-2*l])) badB = 1'b1;
        if (dB[4-2*l] && prevDrvB[5-2*l]) badB = 1'b1;
      end
      nAssert++;
      if (badA) begin
        nFail++;
        $display("FAIL overlap_a t=%0t drv=%b prev=%b", $time, dA, prevDrvA);
      end
      nAssert++;
      if (badB) begin
        nFail++;
        $display("FAIL overlap_b t=%0t drv=%b prev=%b", $time, dB, prevDrvB);
      end
      prevDrvA = dA;
      prevDrvB = dB;
    end
  end

  // ---------------- drivers ----------------
  task automatic set_req(input logic [5:0] r);
    {uh, ul, vh, vl, wh, wl} = r;
  endtask

  task automatic wait_a_uh(input string name);
    for (int k = 0; k < 12 && aUh !== 1'b1; k++) @(negedge clk);
    nAssert++;
    if (aUh !== 1'b1) begin
      nFail++;
      $display("FAIL %s timeout got oUh=%b exp=1", name, aUh);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    set_req(6'b000000);
    en  = 1'b0;
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nAssert++;
      if ({aFault, pinsA} !== {3'b000, cMaskA}) begin
        nFail++;
        $display("FAIL reset_a got=%b exp=%b", {aFault, pinsA}, {3'b000, cMaskA});
      end
      nAssert++;
      if ({bFault, pinsB} !== {3'b000, cMaskB}) begin
        nFail++;
        $display("FAIL reset_b got=%b exp=%b", {bFault, pinsB}, {3'b000, cMaskB});
      end
    end
  endtask

  task automatic test_first_on();
    en = 1'b1;
    set_req(6'b100000);
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      nAssert++;
      if (aUh !== (e >= 3)) begin
        nFail++;
        $display("FAIL first_on edge=%0d got=%b exp=%b", e, aUh, (e >= 3));
      end
    end
    set_req(6'b000000);
    @(negedge clk);
    nAssert++;
    if (aUh !== 1'b0) begin
      nFail++;
      $display("FAIL release got=%b exp=0", aUh);
    end
  endtask

  task automatic test_swap();
    set_req(6'b100000);
    wait_a_uh("swap_on");
    set_req(6'b010000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nAssert++;
      if ({aUh, aUl} !== ((c < 4) ? 2'b00 : 2'b01)) begin
        nFail++;
        $display("FAIL swap cyc=%0d got=%b exp=%b", c, {aUh, aUl}, (c < 4) ? 2'b00 : 2'b01);
      end
    end
  endtask

  task automatic test_fault();
    set_req(6'b100000);
    wait_a_uh("fault_on");
    set_req(6'b101100);
    @(negedge clk);
    set_req(6'b100000);
    nAssert++;
    if (aFault !== 3'b010) begin
      nFail++;
      $display("FAIL fault_set got=%b exp=010", aFault);
    end
    @(negedge clk);
    nAssert++;
    if ((pinsA ^ cMaskA) !== 6'b000000) begin
      nFail++;
      $display("FAIL fault_off got=%b exp=000000", pinsA ^ cMaskA);
    end
    repeat (6) @(negedge clk);
    nAssert++;
    if ({aFault, aUh} !== 4'b0100) begin
      nFail++;
      $display("FAIL fault_hold got=%b exp=0100", {aFault, aUh});
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    nAssert++;
    if ({aFault, aUh} !== 4'b0000) begin
      nFail++;
      $display("FAIL fault_clear got=%b exp=0000", {aFault, aUh});
    end
    wait_a_uh("fault_reon");
  endtask

  task automatic test_clear_race();
    set_req(6'b110000);
    @(negedge clk);
    set_req(6'b001100);
    @(negedge clk);
    nAssert++;
    if (aFault !== 3'b011) begin
      nFail++;
      $display("FAIL race_pre got=%b exp=011", aFault);
    end
    set_req(6'b000011);
    clr = 1'b1;
    @(negedge clk);
    nAssert++;
    if (aFault !== 3'b100) begin
      nFail++;
      $display("FAIL race_set_wins got=%b exp=100", aFault);
    end
    set_req(6'b000000);
    @(negedge clk);
    clr = 1'b0;
    nAssert++;
    if (aFault !== 3'b000) begin
      nFail++;
      $display("FAIL race_clear got=%b exp=000", aFault);
    end
  endtask

  task automatic test_enable();
    set_req(6'b100000);
    wait_a_uh("enable_on");
    en = 1'b0;
    @(negedge clk);
    nAssert++;
    if (aUh !== 1'b0) begin
      nFail++;
      $display("FAIL enable_drop got=%b exp=0", aUh);
    end
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    nAssert++;
    if (aUh !== 1'b0) begin
      nFail++;
      $display("FAIL enable_dead got=%b exp=0", aUh);
    end
    @(negedge clk);
    nAssert++;
    if (aUh !== 1'b1) begin
      nFail++;
      $display("FAIL enable_reon got=%b exp=1", aUh);
    end
  endtask

  task automatic test_toggle();
    int hiCnt, loCnt;
    hiCnt = 0;
    loCnt = 0;
    set_req(6'b000000);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      set_req(((c / 2) % 2 == 0) ? 6'b100000 : 6'b010000);
      @(negedge clk);
      if (bUh === 1'b1) hiCnt++;
      if (bUl === 1'b0) loCnt++;
    end
    nAssert++;
    if (hiCnt < 4 || loCnt < 4) begin
      nFail++;
      $display("FAIL toggle_activity got hi=%0d lo=%0d exp>=4 each", hiCnt, loCnt);
    end
    set_req(6'b000000);
    repeat (2) @(negedge clk);
    nAssert++;
    if ({bUh, bUl} !== 2'b01) begin
      nFail++;
      $display("FAIL toggle_idle_pins got=%b exp=01", {bUh, bUl});
    end
  endtask

  task automatic test_reset_mid();
    set_req(6'b100000);
    wait_a_uh("mid_on");
    set_req(6'b010000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nAssert++;
    if ({aFault, pinsA, bFault, pinsB} !== {3'b000, cMaskA, 3'b000, cMaskB}) begin
      nFail++;
      $display("FAIL reset_mid got=%b exp=%b", {aFault, pinsA, bFault, pinsB},
               {3'b000, cMaskA, 3'b000, cMaskB});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_req(6'b000000);
  endtask

  task automatic test_random();
    int mode[3];
    int active;
    active = 0;
    for (int l = 0; l < 3; l++) mode[l] = 2;
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < 3; l++) begin
        if (mode[l] == 3) mode[l] = 2;
        else if ($urandom_range(0, 5) == 0) begin
          int r;
          r = $urandom_range(0, 39);
          mode[l] = (r < 18) ? 0 : (r < 36) ? 1 : (r < 39) ? 2 : 3;
        end
      end
      uh = (mode[0] == 0) || (mode[0] == 3);
      ul = (mode[0] == 1) || (mode[0] == 3);
      vh = (mode[1] == 0) || (mode[1] == 3);
      vl = (mode[1] == 1) || (mode[1] == 3);
      wh = (mode[2] == 0) || (mode[2] == 3);
      wl = (mode[2] == 1) || (mode[2] == 3);
      en  = ($urandom_range(0, 49) != 0);
      clr = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if ((pinsA ^ cMaskA) != 6'b000000) active++;
    end
    clr = 1'b0;
    set_req(6'b000000);
    nAssert++;
    if (active < 50) begin
      nFail++;
      $display("FAIL random_activity got=%0d exp>=50", active);
    end
  endtask

  initial begin
    test_reset();
    test_first_on();
    test_swap();
    test_fault();
    test_clear_race();
    test_enable();
    test_toggle();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
